// File: rtl/distributor.sv
// rtl/distributor.sv - splits a wide word into ITEM_COUNT items emitted one per cycle
// Optional macro DISTRIBUTOR_COUNT_EN adds in_count to select how many items each word carries.
module distributor #(
    parameter int DATA_WIDTH      = 8,
    parameter int ITEM_COUNT      = 3,
    parameter int ITEM_COUNT_BITS = $clog2(ITEM_COUNT + 1)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [DATA_WIDTH*ITEM_COUNT-1:0] in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_last,
`ifdef DISTRIBUTOR_COUNT_EN
    input  logic [ITEM_COUNT_BITS-1:0]       in_count,
`endif
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last
);

    typedef enum logic {EMPTY = 1'b0, EMIT = 1'b1} state_t;

    localparam logic [ITEM_COUNT_BITS-1:0] FULL_N = ITEM_COUNT_BITS'(ITEM_COUNT);

    state_t                            state_q, state_d;
    logic [DATA_WIDTH*ITEM_COUNT-1:0]  word_q, word_d;
    logic                              last_q, last_d;
    logic [ITEM_COUNT_BITS-1:0]        n_q, n_d;
    logic [ITEM_COUNT_BITS-1:0]        index_q, index_d;

    logic                              busy;
    logic                              final_item;
    logic                              in_fire;
    logic                              out_fire;
    logic [ITEM_COUNT_BITS-1:0]        n_in;
    logic [DATA_WIDTH-1:0]             item;

`ifdef DISTRIBUTOR_COUNT_EN
    // A zero or oversized count means a full word.
    assign n_in = (in_count == '0 || in_count > FULL_N) ? FULL_N : in_count;
`else
    assign n_in = FULL_N;
`endif

    assign busy       = (state_q == EMIT);
    assign final_item = (index_q == n_q - ITEM_COUNT_BITS'(1));
    assign out_fire   = busy && out_ready;
    // The next word may load while the final item of the current one leaves, so no bubble.
    assign in_ready   = !reset && (!busy || (out_ready && final_item));
    assign in_fire    = in_valid && in_ready;

    always_comb begin
        item = '0;
        for (int i = 0; i < ITEM_COUNT; i++) begin
            if (index_q == ITEM_COUNT_BITS'(i)) begin
                item = word_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign out_valid = busy;
    assign out_data  = busy ? item : '0;
    assign out_last  = busy && last_q && final_item;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        last_d  = last_q;
        n_d     = n_q;
        index_d = index_q;
        if (in_fire) begin
            state_d = EMIT;
            word_d  = in_data;
            last_d  = in_last;
            n_d     = n_in;
            index_d = '0;
        end else if (out_fire) begin
            if (final_item) begin
                state_d = EMPTY;
            end else begin
                index_d = index_q + ITEM_COUNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            word_q  <= '0;
            last_q  <= 1'b0;
            n_q     <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            last_q  <= last_d;
            n_q     <= n_d;
            index_q <= index_d;
        end
    end

endmodule
